// File: rtl/pdm_pkg.sv
// Shared types and default parameters for the PDM array scheduler.
package pdm_pkg;

  localparam int unsigned N_CH_DEF    = 20;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned CLK_DIV_DEF = 16;
  localparam int unsigned DECIM_DEF   = 16;

  localparam int unsigned CH_W = $clog2(N_CH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/pdm_clock_gen.sv
// PDM bit clock, per-bit sample pulse and decimation strobe generator.
module pdm_clock_gen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DECIM   = DECIM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pdm_clk,
  output logic pdm_sample,
  output logic dec_strobe
);

  localparam int unsigned C_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned D_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [C_W-1:0] c;
  logic [D_W-1:0] d;
  logic           c_wrap;
  logic           d_wrap;

  assign c_wrap = (c == C_W'(CLK_DIV - 1));
  assign d_wrap = (d == D_W'(DECIM - 1));

  // Half-period divider, bit clock toggle, sample pulse after each falling edge, decimation count.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      c          <= '0;
      d          <= '0;
      pdm_clk    <= 1'b0;
      pdm_sample <= 1'b0;
      dec_strobe <= 1'b0;
    end else begin
      c          <= c_wrap ? '0 : c + C_W'(1);
      if (c_wrap) begin
        pdm_clk <= ~pdm_clk;
      end
      // pdm_clk high at the wrap means this toggle is a falling edge
      pdm_sample <= c_wrap && pdm_clk;
      if (pdm_sample) begin
        d <= d_wrap ? '0 : d + D_W'(1);
      end
      dec_strobe <= pdm_sample && d_wrap;
    end
  end

endmodule

// File: rtl/pdm_array_scheduler.sv
// PDM array timing controller plus snapshot/serializer of all CIC lane outputs.
module pdm_array_scheduler
  import pdm_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DECIM   = DECIM_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_CH*DATA_W-1:0]   cic_data,
  output logic                     pdm_clk,
  output logic                     pdm_sample,
  output logic                     dec_strobe,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(N_CH)-1:0]  m_chan,
  output logic                     m_first,
  output logic                     m_last,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned CHN_W = $clog2(N_CH);
  localparam logic [CHN_W-1:0] LAST_CH = CHN_W'(N_CH - 1);

  state_t             state;
  state_t             state_nx;
  logic [CHN_W-1:0]   ch;
  logic [CHN_W-1:0]   ch_nx;
  logic [DATA_W-1:0]  snap [N_CH];
  logic [DATA_W-1:0]  data_nx;
  logic               cap;
  logic               load;
  logic               ovf_set;

  pdm_clock_gen #(
    .CLK_DIV (CLK_DIV),
    .DECIM   (DECIM)
  ) u_clock_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pdm_clk    (pdm_clk),
    .pdm_sample (pdm_sample),
    .dec_strobe (dec_strobe)
  );

  // The strobe is consumed on the edge after it was raised, once the lanes have dumped.
  assign cap = dec_strobe;

  // Serializer next-state, snapshot load and overflow detection.
  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    load     = 1'b0;
    ovf_set  = 1'b0;
    data_nx  = '0;
    case (state)
      IDLE: begin
        if (cap) begin
          load     = 1'b1;
          ch_nx    = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        // a capture while a frame is still out (even on its last beat) is dropped
        ovf_set = cap;
        if (m_ready) begin
          if (ch == LAST_CH) begin
            ch_nx    = '0;
            state_nx = IDLE;
          end else begin
            ch_nx = ch + CHN_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == SEND) begin
      data_nx = load ? cic_data[DATA_W-1:0] : snap[ch_nx];
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
    end
  end

  // Frame snapshot of every lane, taken only when a capture is accepted.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        snap[i] <= cic_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered stream outputs, derived from the next beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      m_valid <= (state_nx == SEND);
      m_data  <= data_nx;
      m_chan  <= ch_nx;
      m_first <= (state_nx == SEND) && (ch_nx == '0);
      m_last  <= (state_nx == SEND) && (ch_nx == LAST_CH);
    end
  end

  // Sticky dropped-frame flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
